// File: rtl/idex_latch.sv
// ----------------------------------------------------------------------------
// idex_latch
//
// ID/EX pipeline register of the five-stage core. Captures the decoded
// operands and control of the instruction in ID and presents them to EX as
// the *_o2 stage signals. Also:
//   - detects load-use hazards against the instruction currently in EX and
//     inserts exactly one bubble while asking the front end to hold
//     (stall_id),
//   - squashes the ID instruction on a taken branch/jump (flush),
//   - keeps a saturating count of load-use bubbles for the perf counters.
//
// Ports
//   CLK, nRST               clock, asynchronous active-low reset
//   en                      pipeline advance; state only updates when high
//   flush                   squash the ID instruction (load a bubble)
//   id_rdat1/id_rdat2       register file read data
//   id_ext, id_npc          extended immediate, PC+4
//   id_rsel1/2, id_wsel     source / destination register numbers
//   id_wen, id_memread,
//   id_memwrite, id_halt    control bits
//   id_ALUSrc, id_aluop     B-operand select, ALU operation
//   *_o2                    registered copies of the above (EX stage)
//   stall_id                combinational: hold PC and IF/ID this cycle
//   bubble_cnt              saturating load-use bubble count
// ----------------------------------------------------------------------------
module idex_latch #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic [31:0]      id_rdat1,
    input  logic [31:0]      id_rdat2,
    input  logic [31:0]      id_ext,
    input  logic [31:0]      id_npc,
    input  logic [4:0]       id_rsel1,
    input  logic [4:0]       id_rsel2,
    input  logic [4:0]       id_wsel,
    input  logic             id_wen,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_halt,
    input  logic [1:0]       id_ALUSrc,
    input  logic [3:0]       id_aluop,
    output logic [31:0]      rdat1_o2,
    output logic [31:0]      rdat2_o2,
    output logic [31:0]      ext_o2,
    output logic [31:0]      npc_o2,
    output logic [4:0]       rsel1_o2,
    output logic [4:0]       rsel2_o2,
    output logic [4:0]       wsel_o2,
    output logic             wen_o2,
    output logic             memread_o2,
    output logic             memwrite_o2,
    output logic             halt_o2,
    output logic [1:0]       ALUSrc_o2,
    output logic [3:0]       aluop_o2,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt
);

    // B-operand select and ALU op encodings used by the bubble value.
    localparam logic [1:0] RDAT2_DIAOSI = 2'd0;
    localparam logic [1:0] EXT_DIAOSI   = 2'd1;
    localparam logic [3:0] ALU_SLL      = 4'd0;

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic [31:0]      r_rdat1, r_rdat2, r_ext, r_npc;
    logic [4:0]       r_rsel1, r_rsel2, r_wsel;
    logic             r_wen, r_memread, r_memwrite, r_halt;
    logic [1:0]       r_alusrc;
    logic [3:0]       r_aluop;
    logic [CNT_W-1:0] r_bubble_cnt;

    // ------------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------------
    logic w_load_in_ex;
    logic w_dep_rs;
    logic w_dep_rt_alu;
    logic w_dep_rt_store;
    logic w_hz;

    // A bubble has memread = 0 and wen = 0, so it can never raise a hazard;
    // that is what limits a load-use stall to a single en cycle.
    assign w_load_in_ex   = r_memread & r_wen & (r_wsel != 5'd0);
    assign w_dep_rs       = (r_wsel == id_rsel1);
    // rt is only a true source when it feeds the ALU B operand or is store data.
    assign w_dep_rt_alu   = (r_wsel == id_rsel2) & (id_ALUSrc == RDAT2_DIAOSI);
    assign w_dep_rt_store = (r_wsel == id_rsel2) & id_memwrite;
    assign w_hz           = w_load_in_ex & (w_dep_rs | w_dep_rt_alu | w_dep_rt_store);

    // Flush wins: the dependent instruction is being squashed anyway.
    assign stall_id = w_hz & ~flush;

    // ------------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------------
    logic w_load_bubble;
    logic w_capture;
    logic w_cnt_inc;
    logic w_cnt_sat;

    assign w_cnt_sat = &r_bubble_cnt;

    always_comb begin
        w_load_bubble = 1'b0;
        w_capture     = 1'b0;
        w_cnt_inc     = 1'b0;
        if (en) begin
            if (flush) begin
                w_load_bubble = 1'b1;
            end else if (w_hz) begin
                w_load_bubble = 1'b1;
                w_cnt_inc     = ~w_cnt_sat;
            end else begin
                w_capture = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rdat1     <= 32'd0;
            r_rdat2     <= 32'd0;
            r_ext       <= 32'd0;
            r_npc       <= 32'd0;
            r_rsel1     <= 5'd0;
            r_rsel2     <= 5'd0;
            r_wsel      <= 5'd0;
            r_wen       <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_halt      <= 1'b0;
            r_alusrc    <= RDAT2_DIAOSI;
            r_aluop     <= ALU_SLL;
        end else if (w_load_bubble) begin
            r_rdat1     <= 32'd0;
            r_rdat2     <= 32'd0;
            r_ext       <= 32'd0;
            r_npc       <= 32'd0;
            r_rsel1     <= 5'd0;
            r_rsel2     <= 5'd0;
            r_wsel      <= 5'd0;
            r_wen       <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_halt      <= 1'b0;
            r_alusrc    <= RDAT2_DIAOSI;
            r_aluop     <= ALU_SLL;
        end else if (w_capture) begin
            r_rdat1     <= id_rdat1;
            r_rdat2     <= id_rdat2;
            r_ext       <= id_ext;
            r_npc       <= id_npc;
            r_rsel1     <= id_rsel1;
            r_rsel2     <= id_rsel2;
            r_wsel      <= id_wsel;
            r_wen       <= id_wen;
            r_memread   <= id_memread;
            r_memwrite  <= id_memwrite;
            r_halt      <= id_halt;
            r_alusrc    <= id_ALUSrc;
            r_aluop     <= id_aluop;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bubble_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    // EXT_DIAOSI is part of the select encoding but only decoded in EX.
    logic w_unused;
    assign w_unused = (EXT_DIAOSI == 2'd1);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rdat1_o2    = r_rdat1;
    assign rdat2_o2    = r_rdat2;
    assign ext_o2      = r_ext;
    assign npc_o2      = r_npc;
    assign rsel1_o2    = r_rsel1;
    assign rsel2_o2    = r_rsel2;
    assign wsel_o2     = r_wsel;
    assign wen_o2      = r_wen;
    assign memread_o2  = r_memread;
    assign memwrite_o2 = r_memwrite;
    assign halt_o2     = r_halt;
    assign ALUSrc_o2   = r_alusrc;
    assign aluop_o2    = r_aluop;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: doc/idex_latch.md
# idex_latch

Pipeline register between decode (ID) and execute (EX) of the five-stage core. It captures decoded operands and control, and produces the `_o2` stage signals the forwarding logic and ALU consume. It also detects load-use hazards, inserting exactly one bubble and stalling the front end. It applies branch/jump flushes and keeps a saturating count of inserted bubbles for performance counters.

## Interface
- `CNT_W`, default 16: width of the bubble counter.
- `CLK`  in  1: pipeline clock.
- `nRST`  in  1: asynchronous, active-low reset.
- `en`  in  1: pipeline advance (instruction/data memory ready); register updates only when high.
- `flush`  in  1: squash the instruction in ID (taken branch/jump resolved downstream).
- `id_rdat1`, `id_rdat2`  in  32: register file read data.
- `id_ext`  in  32: extended immediate.
- `id_npc`  in  32: PC+4 of the ID instruction.
- `id_rsel1`, `id_rsel2`  in  5: source register numbers (rs, rt).
- `id_wsel`  in  5: destination register.
- `id_wen`, `id_memread`, `id_memwrite`, `id_halt`  in  1: control bits.
- `id_ALUSrc`  in  2: B-operand select (`RDAT2_DIAOSI`/`EXT_DIAOSI`/...).
- `id_aluop`  in  4: ALU operation (`aluop_t`).
- `rdat1_o2`, `rdat2_o2`, `ext_o2`, `npc_o2`  out  32: registered data.
- `rsel1_o2`, `rsel2_o2`, `wsel_o2`  out  5: registered selects.
- `wen_o2`, `memread_o2`, `memwrite_o2`, `halt_o2`  out  1: registered control.
- `ALUSrc_o2`  out  2; `aluop_o2`  out  4.
- `stall_id`  out  1: hold PC and IF/ID register this cycle (combinational).
- `bubble_cnt`  out  `CNT_W`: saturating count of load-use bubbles.

## Operation
- Hazard: `hz = memread_o2 & wen_o2 & (wsel_o2 != 0) & ((wsel_o2 == id_rsel1) | (wsel_o2 == id_rsel2 & id_ALUSrc == RDAT2_DIAOSI) | (wsel_o2 == id_rsel2 & id_memwrite))`.
- `stall_id = hz & ~flush`. It is independent of `en`, but the front end only acts on it when `en` is high.
- Per clock edge with `en` = 1, in priority order:
  1. `flush`: load a bubble. There is no stall and no counter change.
  2. `hz`: load a bubble and increment `bubble_cnt`, saturating at all-ones.
  3. Otherwise: capture all `id_*` fields into the `_o2` registers.
- Bubble: every `_o2` output is 0. That is `wen`/`memread`/`memwrite`/`halt` = 0, selects = 0, data = 0, `ALUSrc_o2 = RDAT2_DIAOSI`, `aluop_o2 = ALU_SLL` (encoding 0).
- With `en` = 0, all registers and `bubble_cnt` hold. A pending `flush` is not remembered; the source holds it until `en`.
- A bubble never triggers `hz`, so a load-use stall lasts exactly one `en` cycle. After that, the load is in MEM and forwarding from `_o3` covers the dependency.
- `halt_o2` is a plain registered bit. Sticky halt is owned downstream.

## Timing
- Reset (`nRST` low, asynchronous): all `_o2` outputs are at bubble values and `bubble_cnt = 0`. `stall_id` is therefore 0.
- Reset asserted mid-stall clears the state immediately. The first edge after release behaves as normal capture.
- Latency: `id_*` appears on `_o2` one `en` edge after presentation.
- `stall_id` follows `_o2` and `id_*` within the same cycle, with no register in the path.
- Stall and flush in the same cycle: flush wins, `stall_id` = 0, no count.
- `bubble_cnt` saturates: it stays at `2^CNT_W - 1` on further hazards.

## Test plan
- Reset:
  - Stimulus: assert `nRST` = 0 mid-cycle with `_o2` holding `wen` = 1, `wsel` = 5.
  - Response: outputs go to bubble values immediately (`wen_o2` = 0, `wsel_o2` = 0, `bubble_cnt` = 0) without a clock edge.
- Normal capture:
  - Stimulus: `en` = 1; ID presents `addu $3,$1,$2` (`rsel1` = 1, `rsel2` = 2, `wsel` = 3, `wen` = 1, `rdat1` = 0x10, `rdat2` = 0x20).
  - Response: next edge gives `_o2` = 1/2/3/1 and `rdat1_o2` = 0x10, `rdat2_o2` = 0x20; `stall_id` = 0.
- Load-use via rs:
  - Stimulus: `lw $4` in `_o2` (`memread` = 1, `wen` = 1, `wsel` = 4); ID has `rsel1` = 4.
  - Response: `stall_id` = 1 that cycle; next edge gives a bubble and `bubble_cnt` = 1; the following cycle has `stall_id` = 0 and the ID instruction is captured.
- Hazard qualifiers:
  - Stimulus: same load with ID `rsel2` = 4 and `ALUSrc` = `EXT_DIAOSI`, no `memwrite`.
  - Response: no stall. With `id_memwrite` = 1: stall. With `wsel_o2` = 0: no stall.
- Flush priority and `en` hold:
  - Stimulus: hazard plus `flush` = 1 with `en` = 1.
  - Response: bubble, `stall_id` = 0, count unchanged.
  - Stimulus: repeat the hazard with `en` = 0 for 3 cycles.
  - Response: `_o2` and count hold and `stall_id` stays 1; the bubble is inserted on the first `en` edge.
- Saturation:
  - Stimulus: `CNT_W` = 2; force 5 consecutive load-use hazards.
  - Response: `bubble_cnt` goes 1, 2, 3, 3, 3.
